// File: rtl/cpu_control_unit.sv
// Multicycle fetch/decode/execute controller for the 8-bit CPU: owns pc, ir, a 4x8 register file and zflag.
// Latency: NOP/HALT 2 cycles, ADD/SUB 3 cycles, LDI/JZ 4 cycles, OUT 3 cycles plus any out_ready stall.
// Backpressure: OUT holds in OUTW with out_valid high and out_data stable until out_ready is seen at a clock edge.
module cpu_control_unit #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] imem_addr,
   input  logic [7:0] imem_rdata,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_opcode,
   input  logic [7:0] alu_result,
   input  logic       alu_zero,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       zflag,
   output logic       halted
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_IMM_A  = 3'd3,
      S_IMM_D  = 3'd4,
      S_OUTW   = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_LDI = 2'b10;
   localparam logic [1:0] SUB_NOP = 2'b00;
   localparam logic [1:0] SUB_JZ  = 2'b01;
   localparam logic [1:0] SUB_OUT = 2'b10;

   state_t     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] ir_q, ir_d;
   logic [7:0] regs_q [4];
   logic [7:0] regs_d [4];
   logic       zflag_q, zflag_d;
   logic       out_valid_q, out_valid_d;
   logic [7:0] out_data_q, out_data_d;

   // Fields of the byte arriving from memory while in DECODE (ir is not loaded yet).
   logic [1:0] dec_op, dec_rd, dec_sub;
   assign dec_op  = imem_rdata[7:6];
   assign dec_rd  = imem_rdata[5:4];
   assign dec_sub = imem_rdata[1:0];

   // pc always addresses memory; the ALU sees the latched instruction's operands every cycle.
   assign imem_addr  = pc_q;
   assign alu_a      = regs_q[ir_q[5:4]];
   assign alu_b      = regs_q[ir_q[3:2]];
   assign alu_opcode = {2'b00, ir_q[6]};
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign zflag      = zflag_q;
   assign halted     = (state_q == S_HALT);

   // Architectural state; an asserted reset discards any in-flight instruction without writeback.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_PC;
         ir_q        <= 8'h00;
         zflag_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         for (int i = 0; i < 4; i++) regs_q[i] <= 8'h00;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         zflag_q     <= zflag_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         regs_q      <= regs_d;
      end
   end

   // Next-state and datapath updates for each phase of an instruction.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      zflag_d     = zflag_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      regs_d      = regs_q;
      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            ir_d = imem_rdata;
            pc_d = pc_q + 8'd1;
            case (dec_op)
               OP_ADD, OP_SUB: state_d = S_EXEC;
               OP_LDI:         state_d = S_IMM_A;
               default: begin
                  case (dec_sub)
                     SUB_NOP: state_d = S_FETCH;
                     SUB_JZ:  state_d = S_IMM_A;
                     SUB_OUT: begin
                        // Capture the data on entry so it cannot move while valid is up.
                        out_valid_d = 1'b1;
                        out_data_d  = regs_q[dec_rd];
                        state_d     = S_OUTW;
                     end
                     default: state_d = S_HALT;
                  endcase
               end
            endcase
         end
         S_EXEC: begin
            regs_d[ir_q[5:4]] = alu_result;
            zflag_d           = alu_zero;
            state_d           = S_FETCH;
         end
         S_IMM_A: state_d = S_IMM_D;
         S_IMM_D: begin
            if (ir_q[7:6] == OP_LDI) begin
               regs_d[ir_q[5:4]] = imem_rdata;
               pc_d              = pc_q + 8'd1;
            end else if (ir_q[1:0] == SUB_JZ) begin
               pc_d = zflag_q ? imem_rdata : pc_q + 8'd1;
            end
            state_d = S_FETCH;
         end
         S_OUTW: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_FETCH;
            end
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

endmodule
